// File: rtl/run_control_pkg.sv
// run_control_pkg: state encodings and default constants shared by run_control and its button path
package run_control_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STEP_INST = 2'd2,
        HALTED    = 2'd3
    } state_t;

    localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
    localparam logic [15:0] DEF_RUN_DIV         = 16'd1;
    localparam int          DEF_CNT_W           = 16;

endpackage

// File: rtl/run_control_if.sv
// run_control_if: operator/controller signals exchanged with the run_control stage
interface run_control_if
    import run_control_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic             run_btn;
    logic             step_btn;
    logic             step_inst;
    logic             end_sq;
    logic             halt;
    logic             cpu_tick;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output run_btn, step_btn, step_inst, end_sq, halt,
        input  cpu_tick, running, halted, cycle_count
    );

    modport slave (
        input  run_btn, step_btn, step_inst, end_sq, halt,
        output cpu_tick, running, halted, cycle_count
    );

endinterface

// File: rtl/run_control_btn_debounce.sv
// btn_debounce: synchronises a raw button, debounces it and emits one pulse per accepted press
module btn_debounce
    import run_control_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic        sync_a;
    logic        sync_b;
    logic        level;
    logic        accept;
    logic [15:0] count;

    // the level flips on the DEBOUNCE_CYCLES-th consecutive sample that disagrees with it;
    // the press pulse is taken combinationally so the FSM can register its tick on that same edge
    assign accept = (sync_b != level) && (count == DEBOUNCE_CYCLES - 16'd1);
    assign press  = accept && sync_b;

    // two-flop synchroniser feeding a consecutive-sample counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            count  <= '0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            if (sync_b == level) begin
                count <= '0;
            end else if (accept) begin
                level <= sync_b;
                count <= '0;
            end else begin
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/run_control.sv
// run_control: turns run/step buttons into single-cycle cpu_tick pulses for the CPU controller
module run_control
    import run_control_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [15:0] RUN_DIV         = DEF_RUN_DIV,
    parameter int          CNT_W           = DEF_CNT_W
) (
    input logic          clock,
    input logic          reset,
    run_control_if.slave bus
);

    state_t           state;
    logic             run_press;
    logic             step_press;
    logic             ticking;
    logic             fire;
    logic             done;
    logic             tick_next;
    logic             stop_pending;
    logic             cpu_tick;
    logic             running;
    logic             halted;
    logic [15:0]      div;
    logic [CNT_W-1:0] cycle_count;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clock (clock),
        .reset (reset),
        .btn   (bus.run_btn),
        .press (run_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clock (clock),
        .reset (reset),
        .btn   (bus.step_btn),
        .press (step_press)
    );

    // divided-rate tick, instruction-boundary exit and the next value of cpu_tick;
    // run wins over a simultaneous step, and halt suppresses any tick due this clock
    always_comb begin
        ticking   = (state == RUN) || (state == STEP_INST);
        fire      = ticking && (div == RUN_DIV - 16'd1);
        done      = fire && bus.end_sq && ((state == STEP_INST) || stop_pending);
        tick_next = !bus.halt && (fire || ((state == IDLE) && step_press && !run_press && !bus.step_inst));
    end

    // control FSM with registered outputs; halt overrides every state until reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            div          <= '0;
            stop_pending <= 1'b0;
            cpu_tick     <= 1'b0;
            running      <= 1'b0;
            halted       <= 1'b0;
            cycle_count  <= '0;
        end else begin
            cpu_tick     <= tick_next;
            div          <= (ticking && !fire) ? div + 16'd1 : '0;
            stop_pending <= (state == RUN) && !done && (stop_pending || run_press);
            if (tick_next) cycle_count <= cycle_count + CNT_W'(1);
            if (bus.halt) begin
                state   <= HALTED;
                running <= 1'b0;
                halted  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (run_press) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end else if (step_press && bus.step_inst) begin
                            state   <= STEP_INST;
                            running <= 1'b1;
                        end
                    end
                    RUN, STEP_INST: begin
                        if (done) begin
                            state   <= IDLE;
                            running <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.cpu_tick    = cpu_tick;
    assign bus.running     = running;
    assign bus.halted      = halted;
    assign bus.cycle_count = cycle_count;

endmodule
